// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Package  : md_pkg
// Summary  : Op codes, op-class helpers and default sizing for the MD unit.
// Revision : 1.0
// ============================================================================
package md_pkg;

  localparam int c_def_width   = 32;
  localparam int c_def_mul_lat = 5;
  localparam int c_def_div_lat = 10;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_MTHI  = 4'd8,
    MD_MTLO  = 4'd9
  } md_op_t;

  function automatic logic is_mul_class(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div_class(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_mt(input md_op_t op);
    return op inside {MD_MTHI, MD_MTLO};
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Summary  : Combinational multiply / accumulate / divide datapath.
// Revision : 1.0
// ============================================================================
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = c_def_width
) (
  input  md_op_t             op,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result,
  output logic               write_en
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic               w_sgn;
  logic               w_neg1;
  logic               w_neg2;
  logic               w_div_zero;
  logic [2*WIDTH-1:0] w_ext1;
  logic [2*WIDTH-1:0] w_ext2;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  // Extending to 2*WIDTH and keeping the low half gives both signed and unsigned products.
  always_comb begin
    w_sgn  = is_signed_op(op);
    w_ext1 = {{WIDTH{w_sgn & d1[WIDTH-1]}}, d1};
    w_ext2 = {{WIDTH{w_sgn & d2[WIDTH-1]}}, d2};
    w_prod = w_ext1 * w_ext2;
    w_acc  = {hi, lo};
  end

  // Divide on magnitudes and restore signs; a zero divisor is swapped for 1 and the write suppressed.
  always_comb begin
    w_neg1     = w_sgn & d1[WIDTH-1];
    w_neg2     = w_sgn & d2[WIDTH-1];
    w_abs1     = w_neg1 ? -d1 : d1;
    w_abs2     = w_neg2 ? -d2 : d2;
    w_div_zero = (d2 == '0);
    w_divisor  = w_div_zero ? c_one : w_abs2;
    w_uq       = w_abs1 / w_divisor;
    w_ur       = w_abs1 % w_divisor;
    w_q        = (w_neg1 ^ w_neg2) ? -w_uq : w_uq;
    w_r        = w_neg1 ? -w_ur : w_ur;
  end

  always_comb begin
    result   = w_acc;
    write_en = 1'b1;
    case (op)
      MD_MULT, MD_MULTU: result = w_prod;
      MD_MADD, MD_MADDU: result = w_acc + w_prod;
      MD_MSUB, MD_MSUBU: result = w_acc - w_prod;
      MD_DIV, MD_DIVU: begin
        result   = {w_r, w_q};
        write_en = ~w_div_zero;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_param
// Summary  : Multi-cycle multiply/divide unit with HI/LO registers and flush.
// Revision : 1.0
// ============================================================================
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int MUL_LAT = c_def_mul_lat,
  parameter int DIV_LAT = c_def_div_lat
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_cnt_w   = $clog2(c_max_lat + 1);

  localparam logic [c_cnt_w-1:0] c_mul_cnt = c_cnt_w'(MUL_LAT);
  localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(DIV_LAT);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  logic [0:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  md_op_t             r_op;
  logic [WIDTH-1:0]   r_d1;
  logic [WIDTH-1:0]   r_d2;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  md_op_t             w_op;
  logic               w_accept;
  logic               w_mt_wr;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_result;
  logic               w_write_en;

  assign w_op     = md_op_t'(op);
  assign w_accept = (r_state == c_idle) && start && (is_mul_class(w_op) || is_div_class(w_op));
  assign w_mt_wr  = (r_state == c_idle) && start && is_mt(w_op);
  assign w_commit = (r_state == c_run) && (r_cnt == c_cnt_one);

  // Uses the live HI/LO so accumulate ops see the values present at commit.
  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op       (r_op),
    .d1       (r_d1),
    .d2       (r_d2),
    .hi       (r_hi),
    .lo       (r_lo),
    .result   (w_result),
    .write_en (w_write_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= c_idle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_cnt   <= is_div_class(w_op) ? c_div_cnt : c_mul_cnt;
            r_state <= c_run;
          end
        end
        c_run: begin
          r_cnt <= r_cnt - c_cnt_one;
          if (w_commit) begin
            r_state <= c_idle;
          end
        end
        default: begin
          r_state <= c_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op <= MD_MULT;
      r_d1 <= '0;
      r_d2 <= '0;
    end else if (!flush && w_accept) begin
      r_op <= w_op;
      r_d1 <= d1;
      r_d2 <= d2;
    end
  end

  // Flush outranks both a commit and a move-to write in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!flush) begin
      if (w_commit && w_write_en) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end else if (w_mt_wr) begin
        if (w_op == MD_MTHI) begin
          r_hi <= d1;
        end else begin
          r_lo <= d1;
        end
      end
    end
  end

  assign busy = (r_state == c_run);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit_param
// Summary  : Self-checking bench for md_unit_param (32-bit and 16-bit builds).
// Revision : 1.0
// ============================================================================
module tb_md_unit_param;
  import md_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_start [2];
  logic        s_flush [2];
  logic [3:0]  s_op    [2];
  logic [31:0] s_d1    [2];
  logic [31:0] s_d2    [2];

  logic        busy0, busy1;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Reference state: HI/LO, captured op and cycles still to go per unit
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] m_a  [2];
  logic [31:0] m_b  [2];
  logic [3:0]  m_op [2];
  int          m_left [2];

  md_unit_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) u_dut32 (
    .clk(clk), .reset(reset), .start(s_start[0]), .op(s_op[0]),
    .d1(s_d1[0]), .d2(s_d2[0]), .flush(s_flush[0]),
    .busy(busy0), .hi(hi0), .lo(lo0)
  );

  md_unit_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start[1]), .op(s_op[1]),
    .d1(s_d1[1][15:0]), .d2(s_d2[1][15:0]), .flush(s_flush[1]),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int width_of(input int u);
    return (u == 0) ? 32 : 16;
  endfunction

  function automatic int lat_of(input int u, input logic [3:0] o);
    if (o == MD_MTHI || o == MD_MTLO) return 0;
    if (o == MD_DIV || o == MD_DIVU) return (u == 0) ? 10 : 3;
    return (u == 0) ? 5 : 1;
  endfunction

  // Plain integer arithmetic on 64-bit values, masked to the unit width
  function automatic void ref_op(input int w, input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output logic we, output logic [31:0] rh, output logic [31:0] rl);
    longint m, ua, ub, sa, sb, acc, res, q, r;
    m   = (longint'(1) << w) - 1;
    ua  = longint'({32'b0, a}) & m;
    ub  = longint'({32'b0, b}) & m;
    sa  = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb  = ub[w-1] ? ub - (longint'(1) << w) : ub;
    acc = ((longint'({32'b0, hi}) & m) << w) | (longint'({32'b0, lo}) & m);
    we  = 1'b1;
    res = acc;
    case (o)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = ua * ub;
      MD_MADD:  res = acc + sa * sb;
      MD_MADDU: res = acc + ua * ub;
      MD_MSUB:  res = acc - sa * sb;
      MD_MSUBU: res = acc - ua * ub;
      MD_DIV, MD_DIVU: begin
        if (ub == 0) begin
          we = 1'b0;
        end else begin
          q   = (o == MD_DIV) ? sa / sb : ua / ub;
          r   = (o == MD_DIV) ? sa % sb : ua % ub;
          res = ((r & m) << w) | (q & m);
        end
      end
      default: ;
    endcase
    rh = 32'((res >> w) & m);
    rl = 32'(res & m);
  endfunction

  task automatic model_edge(input int u);
    logic        we;
    logic [31:0] rh, rl, mask;
    mask = (u == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    if (s_flush[u]) begin
      m_left[u] = 0;
    end else if (m_left[u] > 0) begin
      m_left[u] = m_left[u] - 1;
      if (m_left[u] == 0) begin
        ref_op(width_of(u), m_op[u], m_a[u], m_b[u], m_hi[u], m_lo[u], we, rh, rl);
        if (we) begin
          m_hi[u] = rh;
          m_lo[u] = rl;
        end
      end
    end else if (s_start[u]) begin
      if (s_op[u] == MD_MTHI) m_hi[u] = s_d1[u] & mask;
      else if (s_op[u] == MD_MTLO) m_lo[u] = s_d1[u] & mask;
      else if (lat_of(u, s_op[u]) > 0 && s_op[u] <= 4'd9) begin
        m_op[u]   = s_op[u];
        m_a[u]    = s_d1[u];
        m_b[u]    = s_d2[u];
        m_left[u] = lat_of(u, s_op[u]);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int u = 0; u < 2; u++) begin
          m_hi[u] = '0; m_lo[u] = '0; m_left[u] = 0;
        end
      end else begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("busy32", 32'(busy0), 32'(m_left[0] > 0));
        check("hi32",   hi0,        m_hi[0]);
        check("lo32",   lo0,        m_lo[0]);
        check("busy16", 32'(busy1), 32'(m_left[1] > 0));
        check("hi16",   {16'b0, hi1}, m_hi[1]);
        check("lo16",   {16'b0, lo1}, m_lo[1]);
      end
    end
  end

  // Issue at a falling edge and count the falling edges that see busy high
  task automatic run_op(input int u, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    logic bz;
    s_start[u] = 1'b1; s_op[u] = o; s_d1[u] = a; s_d2[u] = b;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_start[u] = 1'b0;
      bz = (u == 0) ? busy0 : busy1;
      if (bz) cyc++;
      else break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'h0000_8000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      s_start[u] = 1'b0; s_flush[u] = 1'b0; s_op[u] = '0; s_d1[u] = '0; s_d2[u] = '0;
    end
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_hi",   hi0, 32'd0);
    check("reset_lo",   lo0, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(0, MD_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_busy_cycles", 32'(cyc), 32'd5);
    check("mult_hi", hi0, 32'hFFFF_FFFF);
    check("mult_lo", lo0, 32'hFFFF_FFFA);

    run_op(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_busy_cycles", 32'(cyc), 32'd10);
    check("div_lo", lo0, 32'hFFFF_FFFD);
    check("div_hi", hi0, 32'hFFFF_FFFF);
    run_op(0, MD_DIVU, 32'd7, 32'd2, cyc);
    check("divu_lo", lo0, 32'd3);
    check("divu_hi", hi0, 32'd1);

    run_op(0, MD_MTHI, 32'h11, 32'd0, cyc);
    check("mthi_no_busy", 32'(cyc), 32'd0);
    run_op(0, MD_MTLO, 32'h22, 32'd0, cyc);
    run_op(0, MD_DIV, 32'd5, 32'd0, cyc);
    check("div0_busy_cycles", 32'(cyc), 32'd10);
    check("div0_hi", hi0, 32'h11);
    check("div0_lo", lo0, 32'h22);

    run_op(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("divovf_lo", lo0, 32'h8000_0000);
    check("divovf_hi", hi0, 32'h0);

    run_op(0, MD_MTHI, 32'hAAAA, 32'd0, cyc);
    run_op(0, MD_MTLO, 32'h5555, 32'd0, cyc);
    s_start[0] = 1'b1; s_op[0] = MD_MULT; s_d1[0] = 32'd7; s_d2[0] = 32'd9;
    @(negedge clk); s_start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); s_flush[0] = 1'b1;
    check("flush_busy_before", 32'(busy0), 32'd1);
    @(negedge clk); s_flush[0] = 1'b0;
    check("flush_busy_after", 32'(busy0), 32'd0);
    check("flush_hi", hi0, 32'hAAAA);
    check("flush_lo", lo0, 32'h5555);

    s_start[0] = 1'b1; s_flush[0] = 1'b1; s_op[0] = MD_MULT;
    @(negedge clk); s_start[0] = 1'b0; s_flush[0] = 1'b0;
    check("start_flush_busy", 32'(busy0), 32'd0);
    check("start_flush_hi", hi0, 32'hAAAA);

    run_op(0, MD_MTHI, 32'h0, 32'd0, cyc);
    run_op(0, MD_MTLO, 32'hFFFF_FFFF, 32'd0, cyc);
    run_op(0, MD_MADDU, 32'd1, 32'd1, cyc);
    check("maddu_hi", hi0, 32'd1);
    check("maddu_lo", lo0, 32'd0);
    run_op(0, MD_MTHI, 32'h0, 32'd0, cyc);
    run_op(0, MD_MTLO, 32'h0, 32'd0, cyc);
    run_op(0, MD_MSUB, 32'd1, 32'd1, cyc);
    check("msub_hi", hi0, 32'hFFFF_FFFF);
    check("msub_lo", lo0, 32'hFFFF_FFFF);

    run_op(1, MD_MULTU, 32'hFFFF, 32'hFFFF, cyc);
    check("w16_busy_cycles", 32'(cyc), 32'd1);
    check("w16_hi", {16'b0, hi1}, 32'hFFFE);
    check("w16_lo", {16'b0, lo1}, 32'h0001);

    run_op(0, MD_MTHI, 32'h5, 32'd0, cyc);
    s_start[0] = 1'b1; s_op[0] = MD_DIV; s_d1[0] = 32'd100; s_d2[0] = 32'd3;
    @(negedge clk); s_start[0] = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_hi",   hi0, 32'd0);
    check("async_rst_lo",   lo0, 32'd0);
    check("async_rst_hi16", {16'b0, hi1}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 300; it++) begin
      int          u, lat, fk;
      logic [3:0]  o;
      u   = int'($urandom % 2);
      o   = 4'($urandom % 10);
      lat = lat_of(u, o);
      fk  = (u == 0 && lat > 0 && ($urandom % 4) == 0) ? int'($urandom_range(1, lat)) : 0;
      s_start[u] = 1'b1; s_op[u] = o; s_d1[u] = pick(); s_d2[u] = pick();
      for (int k = 1; k <= lat + 1; k++) begin
        @(negedge clk);
        s_start[u] = 1'b0;
        s_flush[u] = (k == fk);
        if (fk == 0 && k < lat && ($urandom % 8) == 0) begin
          s_start[u] = 1'b1;
          s_op[u]    = 4'($urandom % 10);
          s_d1[u]    = pick();
        end
      end
      s_start[u] = 1'b0;
      s_flush[u] = 1'b0;
    end

    repeat (15) @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
